// File: rtl/nes_boot_pkg.sv
// Shared definitions for the host boot-stream to GameLoader bridge.
package nes_boot_pkg;

    // First byte of the iNES header magic ("NES\x1A").
    localparam logic [7:0] INES_SYNC_BYTE = 8'h4E;

    // Host 4-phase handshake states.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_e;

    // Index of the byte currently presented from the unpack word.
    typedef logic [1:0] byte_idx_t;

    // Select a byte from a word, index 0 being the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input byte_idx_t idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/boot_word_fifo.sv
// Single-clock word FIFO with registered full/empty flags and a show-ahead
// read port (rdata is the head entry whenever empty is low).
module boot_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    // Flags are registered, so a push into a full FIFO is refused even if a
    // pop frees the slot in the same cycle.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointers, occupancy and flags; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

endmodule

// File: rtl/boot_byte_streamer.sv
// Host boot-word to GameLoader byte bridge: 4-phase word capture, word FIFO,
// MSB-first byte unpacker, rom_size truncation and progress/done reporting.
// Optional feature macro: BOOT_HDR_SYNC_EN -- suppress bytes ahead of the
// first iNES sync byte (they are still counted in bytes_loaded).
module boot_byte_streamer
    import nes_boot_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      host_bootdata,
    input  logic             host_bootdata_req,
    output logic             host_bootdata_ack,
    input  logic [CNT_W-1:0] rom_size,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bytes_loaded,
    output logic             sync_found,
    output logic             done
);

    hs_state_e        state_q, state_d;
    logic [CNT_W-1:0] words_in_q, words_in_d;
    logic             capture, room, push, pop;
    logic             fifo_full, fifo_empty;
    logic [31:0]      fifo_rdata;

    logic [31:0]      word_q, word_d;
    byte_idx_t        idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;
    logic [7:0]       cur_byte;
    logic             present, consume, last;

    boot_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (host_bootdata),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A word is captured (and acked) whenever there is FIFO room; it is only
    // stored while the stream still needs bytes, otherwise silently dropped.
    assign capture = (state_q == IDLE) && host_bootdata_req && !fifo_full;
    assign room    = {words_in_q, 2'b00} < {2'b00, rom_size};
    assign push    = capture && room;
    assign host_bootdata_ack = (state_q == ACK);

    // Handshake next state and accepted-word counter.
    always_comb begin
        state_d    = state_q;
        words_in_d = words_in_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = ACK;
                    if (room) words_in_d = words_in_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (!host_bootdata_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            words_in_q <= '0;
        end else begin
            state_q    <= state_d;
            words_in_q <= words_in_d;
        end
    end

    assign cur_byte = byte_sel(word_q, idx_q);

`ifdef BOOT_HDR_SYNC_EN
    // Until sync, bytes other than the sync byte are swallowed at 1/cycle.
    assign present    = sync_q || (cur_byte == INES_SYNC_BYTE);
    assign sync_d     = sync_q || (busy_q && cur_byte == INES_SYNC_BYTE);
    assign sync_found = sync_d;
`else
    assign present    = 1'b1;
    assign sync_d     = 1'b1;
    assign sync_found = sync_q;
`endif

    assign out_valid    = busy_q && present;
    assign out_data     = out_valid ? cur_byte : 8'h00;
    assign consume      = busy_q && (present ? out_ready : 1'b1);
    assign last         = ({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, rom_size};
    assign bytes_loaded = cnt_q;
    assign done         = (cnt_q == rom_size) && fifo_empty && !busy_q;

    // Unpacker: advance byte index, refill from FIFO on the 4th byte so the
    // output stays back-to-back, stop after the rom_size-th byte.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        pop    = 1'b0;
        if (consume) begin
            if (cnt_q != rom_size) cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end else if (idx_q == 2'd3) begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    word_d = fifo_rdata;
                    idx_d  = 2'd0;
                end else begin
                    busy_d = 1'b0;
                end
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else if (!busy_q && !fifo_empty) begin
            pop    = 1'b1;
            word_d = fifo_rdata;
            idx_d  = 2'd0;
            busy_d = 1'b1;
        end
    end

    // Unpacker, byte counter and sync-flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

endmodule
